// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM.
// States, opcodes, datapath select codes and the control bundle.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALRADR,
        S_JALRPC,
        S_ERROR
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_SLT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Signed compares use only the sign of rs1-rs2 (overflow ignored).
    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       zero,
        input logic       sign
    );
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:  t = zero;
            F3_BNE:  t = ~zero;
            F3_BLT:  t = sign;
            F3_BGE:  t = ~sign;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Funct-field decode to the 3-bit ALU operation for R/I-type and lui.
// Flags slt/slti and unsupported funct3 encodings.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_op_o,
    output logic       is_slt_o,
    output logic       bad_funct_o
);

    logic is_r;
    logic is_lui;

    assign is_r   = (opcode_i == OP_R);
    assign is_lui = (opcode_i == OP_LUI);

    always_comb begin
        alu_op_o    = ALU_ADD;
        is_slt_o    = 1'b0;
        bad_funct_o = 1'b0;
        if (!is_lui) begin
            unique case (funct3_i)
                F3_ADD: alu_op_o = (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
                F3_XOR: alu_op_o = ALU_XOR;
                F3_OR:  alu_op_o = ALU_OR;
                F3_AND: alu_op_o = ALU_AND;
                F3_SLT: begin
                    alu_op_o = ALU_SUB;
                    is_slt_o = 1'b1;
                end
                default: bad_funct_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       SignBit,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] AluOp,
    output logic       SltBit,
    output logic       Illegal
);

    state_e     state_q;
    logic       slt_bit_q;
    logic       slt_sel_q;
    logic       store_q;
    logic [2:0] dec_alu_op;
    logic       dec_is_slt;
    logic       dec_bad;
    ctrl_t      ctrl;
    ctrl_t      ctrl_gated;

    alu_op_decoder u_alu_op_decoder (
        .opcode_i    (Opcode),
        .funct3_i    (Funct3),
        .funct7b5_i  (Funct7b5),
        .alu_op_o    (dec_alu_op),
        .is_slt_o    (dec_is_slt),
        .bad_funct_o (dec_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            slt_bit_q <= 1'b0;
            slt_sel_q <= 1'b0;
            store_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    store_q   <= (Opcode == OP_STORE);
                    slt_sel_q <= 1'b0;
                    case (Opcode)
                        OP_LOAD, OP_STORE: state_q <= S_MEMADR;
                        OP_R:              state_q <= S_EXECR;
                        OP_IMM, OP_LUI:    state_q <= S_EXECI;
                        OP_BRANCH:         state_q <= S_BRANCH;
                        OP_JAL:            state_q <= S_JAL;
                        OP_JALR:           state_q <= S_JALRADR;
                        default:           state_q <= S_ERROR;
                    endcase
                end
                S_MEMADR:   state_q <= store_q ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: state_q <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    if (dec_bad) begin
                        state_q <= S_ERROR;
                    end else begin
                        state_q   <= S_ALUWB;
                        slt_sel_q <= dec_is_slt;
                        if (dec_is_slt) slt_bit_q <= SignBit;
                    end
                end
                S_ALUWB:   state_q <= S_FETCH;
                S_BRANCH:  state_q <= S_FETCH;
                S_JAL:     state_q <= S_ALUWB;
                S_JALRADR: state_q <= S_JALRPC;
                S_JALRPC:  state_q <= S_ALUWB;
                S_ERROR:   state_q <= S_ERROR;
                default:   state_q <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = (Opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = store_q ? IMM_S : IMM_I;
            end
            S_MEMREAD: ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = dec_alu_op;
            end
            S_EXECI: begin
                ctrl.alu_src_a = (Opcode == OP_LUI) ? SRCA_ZERO : SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = (Opcode == OP_LUI) ? IMM_U : IMM_I;
                ctrl.alu_op    = dec_alu_op;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = slt_sel_q ? RES_SLT : RES_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_write  = branch_taken(Funct3, Zero, SignBit);
            end
            S_JAL, S_JALRPC: begin
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_JALRADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
            end
            S_ERROR: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // Gate with reset so nothing is written while rst_n is low.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign PCWrite   = ctrl_gated.pc_write;
    assign AdrSrc    = ctrl_gated.adr_src;
    assign MemWrite  = ctrl_gated.mem_write;
    assign IRWrite   = ctrl_gated.ir_write;
    assign RegWrite  = ctrl_gated.reg_write;
    assign ResultSrc = ctrl_gated.result_src;
    assign ALUSrcA   = ctrl_gated.alu_src_a;
    assign ALUSrcB   = ctrl_gated.alu_src_b;
    assign ImmSrc    = ctrl_gated.imm_src;
    assign AluOp     = ctrl_gated.alu_op;
    assign Illegal   = ctrl_gated.illegal;
    assign SltBit    = slt_bit_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller.
// One table row per clock cycle, plus error and reset sequences.
module tb_multicycle_controller;

    localparam logic [6:0] L_LOAD  = 7'b0000011;
    localparam logic [6:0] L_STORE = 7'b0100011;
    localparam logic [6:0] L_R     = 7'b0110011;
    localparam logic [6:0] L_IMM   = 7'b0010011;
    localparam logic [6:0] L_LUI   = 7'b0110111;
    localparam logic [6:0] L_BR    = 7'b1100011;
    localparam logic [6:0] L_JAL   = 7'b1101111;
    localparam logic [6:0] L_JALR  = 7'b1100111;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [2:0] aop;
        logic       slt;
        logic       ill;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       s;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Opcode = '0;
    logic [2:0] Funct3 = '0;
    logic       Funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       SignBit = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, AluOp;
    logic       SltBit, Illegal;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7, cur_z, cur_s;

    multicycle_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Opcode    (Opcode),
        .Funct3    (Funct3),
        .Funct7b5  (Funct7b5),
        .Zero      (Zero),
        .SignBit   (SignBit),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .AluOp     (AluOp),
        .SltBit    (SltBit),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    function automatic out_t e(
        input logic pcw, adr, mw, irw, rw,
        input logic [1:0] rs, sa, sb,
        input logic [2:0] imm, aop,
        input logic slt, ill
    );
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, aop, slt, ill};
    endfunction

    function automatic out_t fetch(input logic s);
        return e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, s, 0);
    endfunction

    function automatic out_t dec(input logic [2:0] imm, input logic s);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, s, 0);
    endfunction

    function automatic out_t wb(input logic [1:0] rs, input logic s);
        return e(0, 0, 0, 0, 1, rs, 2'b00, 2'b00, 3'b000, 3'b000, s, 0);
    endfunction

    function automatic out_t br(input logic t, input logic s);
        return e(t, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, s, 0);
    endfunction

    function automatic out_t exr(input logic [2:0] aop, input logic s);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, aop, s, 0);
    endfunction

    function automatic out_t exi(input logic [2:0] aop, input logic s);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, aop, s, 0);
    endfunction

    function automatic out_t jmp(input logic s);
        return e(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, s, 0);
    endfunction

    function automatic out_t err(input logic s);
        return e(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, s, 1);
    endfunction

    task automatic ins(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic s);
        cur_op = op;
        cur_f3 = f3;
        cur_f7 = f7;
        cur_z  = z;
        cur_s  = s;
    endtask

    task automatic c(input out_t x);
        vecs.push_back('{cur_op, cur_f3, cur_f7, cur_z, cur_s, x});
    endtask

    task automatic chk(input string nm, input out_t exp);
        out_t act;
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, AluOp, SltBit, Illegal};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input out_t exp);
        #1 chk(nm, exp);
        @(negedge clk);
    endtask

    initial begin
        // add / lw / sw
        ins(L_R, 3'b000, 0, 0, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(exr(3'b000, 0)); c(wb(2'b00, 0));
        ins(L_LOAD, 3'b010, 0, 0, 0);
        c(fetch(0)); c(dec(3'b010, 0));
        c(e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        c(e(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        c(wb(2'b01, 0));
        ins(L_STORE, 3'b010, 0, 0, 0);
        c(fetch(0)); c(dec(3'b010, 0));
        c(e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0, 0));
        c(e(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        // branches
        ins(L_BR, 3'b001, 0, 1, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(0, 0));
        ins(L_BR, 3'b001, 0, 0, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(1, 0));
        ins(L_BR, 3'b101, 0, 0, 1);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(0, 0));
        ins(L_BR, 3'b101, 0, 1, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(1, 0));
        ins(L_BR, 3'b000, 0, 1, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(1, 0));
        ins(L_BR, 3'b100, 0, 0, 1);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(1, 0));
        ins(L_BR, 3'b010, 0, 1, 1);
        c(fetch(0)); c(dec(3'b010, 0)); c(br(0, 0));
        // slt with positive difference, then slti with negative
        ins(L_R, 3'b010, 0, 0, 0);
        c(fetch(0)); c(dec(3'b010, 0)); c(exr(3'b001, 0)); c(wb(2'b11, 0));
        ins(L_IMM, 3'b010, 0, 0, 1);
        c(fetch(0)); c(dec(3'b010, 0)); c(exi(3'b001, 0)); c(wb(2'b11, 1));
        // sub / xor / andi; SltBit stays latched
        ins(L_R, 3'b000, 1, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1)); c(exr(3'b001, 1)); c(wb(2'b00, 1));
        ins(L_R, 3'b100, 0, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1)); c(exr(3'b100, 1)); c(wb(2'b00, 1));
        ins(L_IMM, 3'b111, 1, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1)); c(exi(3'b010, 1)); c(wb(2'b00, 1));
        ins(L_IMM, 3'b110, 0, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1)); c(exi(3'b011, 1)); c(wb(2'b00, 1));
        // jal / jalr / lui
        ins(L_JAL, 3'b000, 0, 0, 0);
        c(fetch(1)); c(dec(3'b011, 1)); c(jmp(1)); c(wb(2'b00, 1));
        ins(L_JALR, 3'b000, 0, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1));
        c(e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1, 0));
        c(jmp(1)); c(wb(2'b00, 1));
        ins(L_LUI, 3'b101, 1, 0, 0);
        c(fetch(1)); c(dec(3'b010, 1));
        c(e(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 1, 0));
        c(wb(2'b00, 1));

        #3 chk("reset_outputs", '0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            Opcode   = vecs[i].op;
            Funct3   = vecs[i].f3;
            Funct7b5 = vecs[i].f7;
            Zero     = vecs[i].z;
            SignBit  = vecs[i].s;
            #1 chk($sformatf("row%0d", i), vecs[i].exp);
            @(negedge clk);
        end

        // illegal opcode locks into ERROR
        Opcode = 7'b0000000;
        Funct3 = 3'b000;
        step("ill_fetch", fetch(1));
        step("ill_decode", dec(3'b010, 1));
        for (int k = 0; k < 12; k++) step($sformatf("ill_err%0d", k), err(1));

        // reset leaves ERROR and clears SltBit
        #2 rst_n = 1'b0;
        #1 chk("rst_async", '0);
        @(negedge clk);
        #1 chk("rst_hold", '0);
        rst_n = 1'b1;
        Opcode = L_R;
        Funct3 = 3'b001;
        step("badf_fetch", fetch(0));
        step("badf_decode", dec(3'b010, 0));
        step("badf_execr", exr(3'b000, 0));
        step("badf_err", err(0));

        // reset asserted in the middle of MEMADR
        rst_n = 1'b0;
        #1 chk("rst2_async", '0);
        @(negedge clk);
        rst_n = 1'b1;
        Opcode = L_LOAD;
        Funct3 = 3'b010;
        step("lw_fetch", fetch(0));
        step("lw_decode", dec(3'b010, 0));
        #1 chk("lw_memadr",
               e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_async", '0);
        @(negedge clk);
        #1 chk("mid_rst_hold", '0);
        rst_n = 1'b1;
        step("re_fetch", fetch(0));
        step("re_decode", dec(3'b010, 0));
        step("re_memadr",
             e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        step("re_memread",
             e(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
        step("re_memwb", wb(2'b01, 0));
        step("re_next_fetch", fetch(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
